// File: rtl/gpr_mp.sv
// gpr_mp: multi-port general-purpose register file for the MIPS datapath.
// Two write ports (W1 has priority over W0), NRD combinational read ports,
// optional same-cycle write-to-read forwarding, optional hardwired-zero r0,
// and a per-register busy scoreboard feeding the hazard logic.
module gpr_mp #(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [AW-1:0]     wsel0,
    input  logic [DW-1:0]     wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     wsel1,
    input  logic [DW-1:0]     wdata1,
    input  logic [NRD*AW-1:0] rsel,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              bset,
    input  logic [AW-1:0]     bsel,
    output logic              busy_any
);

    // Register count widened by one bit so NREG == 2**AW still compares cleanly.
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    // An index addresses real storage: in range, and not the hardwired zero register.
    function automatic logic idx_valid(input logic [AW-1:0] sel);
        return ({1'b0, sel} < NREG_W) &&
               !((ZERO_REG != 0) && (sel == {AW{1'b0}}));
    endfunction

    logic [DW-1:0]   regs_r [NREG];
    logic [NREG-1:0] busy_r;
    logic            busy_any_r;

    logic            w0_act_s;
    logic            w1_act_s;
    logic            set_act_s;
    logic [NREG-1:0] wr0_hit_s;
    logic [NREG-1:0] wr1_hit_s;
    logic [NREG-1:0] set_hit_s;
    logic [NREG-1:0] busy_next_s;
    logic [AW-1:0]   rs_s;

    // Decode write and issue strobes into one-hot per-register hit vectors.
    always_comb begin
        w0_act_s  = we0  && idx_valid(wsel0);
        w1_act_s  = we1  && idx_valid(wsel1);
        set_act_s = bset && idx_valid(bsel);
        for (int r = 0; r < NREG; r++) begin
            wr0_hit_s[r] = w0_act_s  && (wsel0 == AW'(r));
            wr1_hit_s[r] = w1_act_s  && (wsel1 == AW'(r));
            set_hit_s[r] = set_act_s && (bsel  == AW'(r));
        end
    end

    // Next busy state: a newly issued producer outranks the writeback of the old one.
    always_comb begin
        busy_next_s = busy_r;
        for (int r = 0; r < NREG; r++) begin
            if (set_hit_s[r]) begin
                busy_next_s[r] = 1'b1;
            end else if (wr0_hit_s[r] || wr1_hit_s[r]) begin
                busy_next_s[r] = 1'b0;
            end else begin
                busy_next_s[r] = busy_r[r];
            end
        end
    end

    // Register storage; the load-writeback port wins a same-index conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= {DW{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr1_hit_s[r]) begin
                    regs_r[r] <= wdata1;
                end else if (wr0_hit_s[r]) begin
                    regs_r[r] <= wdata0;
                end else begin
                    regs_r[r] <= regs_r[r];
                end
            end
        end
    end

    // Busy scoreboard and its registered summary flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= {NREG{1'b0}};
            busy_any_r <= 1'b0;
        end else begin
            busy_r     <= busy_next_s;
            busy_any_r <= |busy_next_s;
        end
    end

    // Combinational read ports with optional forwarding of this cycle's write data.
    // Forwarding is suppressed under reset so every port reads 0 while rst_n is low.
    always_comb begin
        rdata = {(NRD*DW){1'b0}};
        rbusy = {NRD{1'b0}};
        rs_s  = {AW{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            rs_s = rsel[i*AW +: AW];
            if (idx_valid(rs_s)) begin
                if ((BYPASS != 0) && rst_n && w1_act_s && (wsel1 == rs_s)) begin
                    rdata[i*DW +: DW] = wdata1;
                    rbusy[i]          = 1'b0;
                end else if ((BYPASS != 0) && rst_n && w0_act_s && (wsel0 == rs_s)) begin
                    rdata[i*DW +: DW] = wdata0;
                    rbusy[i]          = 1'b0;
                end else begin
                    rdata[i*DW +: DW] = regs_r[rs_s];
                    rbusy[i]          = busy_r[rs_s];
                end
            end else begin
                rdata[i*DW +: DW] = {DW{1'b0}};
                rbusy[i]          = 1'b0;
            end
        end
    end

    assign busy_any = busy_any_r;

endmodule

// File: tb/tb_gpr_mp.sv
// Scoreboard bench for gpr_mp: two instances (default forwarding config and a
// 24-register, 4-port, 16-bit, non-forwarding config) share the write/issue
// stimulus; expectations come from a plain array model and are checked by a
// separate monitor process.
module tb_gpr_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1, bset;
    logic [4:0]  wsel0, wsel1, bsel;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  rsel_a;
    logic [63:0] rdata_a;
    logic [1:0]  rbusy_a;
    logic        bany_a;
    logic [19:0] rsel_b;
    logic [63:0] rdata_b;
    logic [3:0]  rbusy_b;
    logic        bany_b;

    always #5 clk = ~clk;

    gpr_mp dut_a (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wsel0(wsel0), .wdata0(wdata0),
        .we1(we1), .wsel1(wsel1), .wdata1(wdata1),
        .rsel(rsel_a), .rdata(rdata_a), .rbusy(rbusy_a),
        .bset(bset), .bsel(bsel), .busy_any(bany_a)
    );

    gpr_mp #(.DW(16), .NREG(24), .AW(5), .NRD(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wsel0(wsel0), .wdata0(wdata0[15:0]),
        .we1(we1), .wsel1(wsel1), .wdata1(wdata1[15:0]),
        .rsel(rsel_b), .rdata(rdata_b), .rbusy(rbusy_b),
        .bset(bset), .bsel(bsel), .busy_any(bany_b)
    );

    typedef struct {
        string       name;
        int          dut;
        int          port;
        logic [31:0] d;
        logic        b;
    } exp_t;

    exp_t        q[$];
    event        chk_ev;
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state
    logic [31:0] ma [32];
    bit          ba [32];
    logic [15:0] mb [24];
    bit          bb [24];

    function automatic bit vld(input int sel, input int nreg);
        return (sel != 0) && (sel < nreg);
    endfunction

    task automatic clear_model();
        for (int r = 0; r < 32; r++) begin ma[r] = 32'd0; ba[r] = 1'b0; end
        for (int r = 0; r < 24; r++) begin mb[r] = 16'd0; bb[r] = 1'b0; end
    endtask

    // Expected read of the forwarding instance
    task automatic exp_a(input int s, output logic [31:0] d, output logic b);
        d = 32'd0; b = 1'b0;
        if (vld(s, 32)) begin
            d = ma[s]; b = ba[s];
            if (rst_n && we1 && vld(int'(wsel1), 32) && int'(wsel1) == s) begin
                d = wdata1; b = 1'b0;
            end else if (rst_n && we0 && vld(int'(wsel0), 32) && int'(wsel0) == s) begin
                d = wdata0; b = 1'b0;
            end
        end
    endtask

    // Expected read of the non-forwarding instance
    task automatic exp_b(input int s, output logic [31:0] d, output logic b);
        d = 32'd0; b = 1'b0;
        if (vld(s, 24)) begin
            d = {16'd0, mb[s]}; b = bb[s];
        end
    endtask

    task automatic update_model();
        if (we0 && vld(int'(wsel0), 32)) begin ma[wsel0] = wdata0; ba[wsel0] = 1'b0; end
        if (we1 && vld(int'(wsel1), 32)) begin ma[wsel1] = wdata1; ba[wsel1] = 1'b0; end
        if (bset && vld(int'(bsel), 32)) ba[bsel] = 1'b1;
        if (we0 && vld(int'(wsel0), 24)) begin mb[wsel0] = wdata0[15:0]; bb[wsel0] = 1'b0; end
        if (we1 && vld(int'(wsel1), 24)) begin mb[wsel1] = wdata1[15:0]; bb[wsel1] = 1'b0; end
        if (bset && vld(int'(bsel), 24)) bb[bsel] = 1'b1;
    endtask

    task automatic push(input string name, input int dut, input int port,
                        input logic [31:0] d, input logic b);
        exp_t e;
        e.name = name; e.dut = dut; e.port = port; e.d = d; e.b = b;
        q.push_back(e);
    endtask

    // Let inputs settle, then queue the model's view of every output.
    task automatic settle();
        logic [31:0] d;
        logic        b;
        bit          any;
        #1;
        if (!rst_n) clear_model();
        for (int i = 0; i < 2; i++) begin
            exp_a(int'(rsel_a[i*5 +: 5]), d, b);
            push("model_a", 0, i, d, b);
        end
        any = 1'b0;
        for (int r = 0; r < 32; r++) any |= ba[r];
        push("busy_any_a", 0, -1, 32'd0, any);
        for (int i = 0; i < 4; i++) begin
            exp_b(int'(rsel_b[i*5 +: 5]), d, b);
            push("model_b", 1, i, d, b);
        end
        any = 1'b0;
        for (int r = 0; r < 24; r++) any |= bb[r];
        push("busy_any_b", 1, -1, 32'd0, any);
    endtask

    task automatic tick();
        -> chk_ev;
        @(posedge clk);
        if (rst_n) update_model();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; bset = 1'b0;
        wsel0 = 5'd0; wsel1 = 5'd0; bsel = 5'd0;
        wdata0 = 32'd0; wdata1 = 32'd0;
        rsel_a = 10'd0; rsel_b = 20'd0;
    endtask

    task automatic rand_cycle();
        we0    = ($urandom_range(0, 2) != 0);
        we1    = ($urandom_range(0, 2) == 0);
        wsel0  = 5'($urandom_range(0, 31));
        wsel1  = ($urandom_range(0, 5) == 0) ? wsel0 : 5'($urandom_range(0, 31));
        wdata0 = $urandom;
        wdata1 = $urandom;
        bset   = ($urandom_range(0, 3) == 0);
        bsel   = ($urandom_range(0, 4) == 0) ? wsel0 : 5'($urandom_range(0, 31));
        rsel_a = 10'($urandom);
        if ($urandom_range(0, 3) == 0) rsel_a[4:0] = wsel1;
        if ($urandom_range(0, 3) == 0) rsel_a[9:5] = wsel0;
        rsel_b = 20'($urandom);
        cyc();
    endtask

    // Monitor: drain the expectation queue against the live outputs.
    initial begin
        exp_t        e;
        logic [31:0] ad;
        logic        ab;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.port < 0) begin
                    ad = 32'd0;
                    ab = (e.dut == 0) ? bany_a : bany_b;
                end else if (e.dut == 0) begin
                    ad = rdata_a[e.port*32 +: 32];
                    ab = rbusy_a[e.port];
                end else begin
                    ad = {16'd0, rdata_b[e.port*16 +: 16]};
                    ab = rbusy_b[e.port];
                end
                n_vec++;
                if (ad !== e.d || ab !== e.b) begin
                    n_err++;
                    $display("FAIL %s dut%0d port%0d t=%0t: got data=%h busy=%b, expected data=%h busy=%b",
                             e.name, e.dut, e.port, $time, ad, ab, e.d, e.b);
                end
            end
        end
    end

    initial begin
        idle();
        clear_model();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        // Reset state
        settle();
        push("reset_rd_a", 0, 0, 32'd0, 1'b0);
        push("reset_bany_a", 0, -1, 32'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        cyc();

        // Basic read/write, and r0 stays zero
        we0 = 1'b1; wsel0 = 5'd5; wdata0 = 32'hDEADBEEF; cyc();
        idle(); rsel_a = {5'd0, 5'd5}; rsel_b = {15'd0, 5'd5};
        settle();
        push("rw5_a", 0, 0, 32'hDEADBEEF, 1'b0);
        push("rw5_b", 1, 0, 32'h0000BEEF, 1'b0);
        tick();
        idle(); we0 = 1'b1; wsel0 = 5'd0; wdata0 = 32'h1234; cyc();
        idle();
        settle();
        push("r0_zero", 0, 0, 32'd0, 1'b0);
        tick();

        // Write conflict, then independent writes
        we0 = 1'b1; we1 = 1'b1; wsel0 = 5'd7; wsel1 = 5'd7; wdata0 = 32'h1; wdata1 = 32'h2; cyc();
        wsel0 = 5'd3; wsel1 = 5'd4; wdata0 = 32'h33; wdata1 = 32'h44; cyc();
        idle(); rsel_a = {5'd4, 5'd7};
        settle();
        push("conflict7", 0, 0, 32'h2, 1'b0);
        push("both_stored4", 0, 1, 32'h44, 1'b0);
        tick();
        idle(); rsel_a = {5'd3, 5'd3};
        settle();
        push("both_stored3", 0, 0, 32'h33, 1'b0);
        tick();

        // Forwarding versus stored-value reads
        idle(); we1 = 1'b1; wsel1 = 5'd9; wdata1 = 32'hA5A5A5A5;
        rsel_a = {5'd9, 5'd0}; rsel_b = {10'd0, 5'd9, 5'd0};
        settle();
        push("bypass_a", 0, 1, 32'hA5A5A5A5, 1'b0);
        push("nobypass_old_b", 1, 1, 32'h0, 1'b0);
        tick();
        idle(); rsel_b = {10'd0, 5'd9, 5'd0};
        settle();
        push("nobypass_new_b", 1, 1, 32'h0000A5A5, 1'b0);
        tick();

        // Busy scoreboard
        idle(); bset = 1'b1; bsel = 5'd12; cyc();
        idle(); rsel_a = {5'd0, 5'd12};
        settle();
        push("busy12", 0, 0, 32'd0, 1'b1);
        push("busy_any_set", 0, -1, 32'd0, 1'b1);
        tick();
        idle(); we0 = 1'b1; wsel0 = 5'd12; wdata0 = 32'h12; rsel_a = {5'd0, 5'd12};
        settle();
        push("busy_fwd_clear", 0, 0, 32'h12, 1'b0);
        tick();
        idle(); rsel_a = {5'd0, 5'd12};
        settle();
        push("busy_any_clr", 0, -1, 32'd0, 1'b0);
        tick();
        idle(); we0 = 1'b1; wsel0 = 5'd12; wdata0 = 32'h99; bset = 1'b1; bsel = 5'd12; cyc();
        idle(); rsel_a = {5'd0, 5'd12};
        settle();
        push("set_wins", 0, 0, 32'h99, 1'b1);
        tick();
        idle(); we0 = 1'b1; wsel0 = 5'd12; wdata0 = 32'h0; cyc();

        // Smaller configuration: out-of-range index and four independent ports
        idle(); we0 = 1'b1; wsel0 = 5'd1; wdata0 = 32'h1111; we1 = 1'b1; wsel1 = 5'd2; wdata1 = 32'h2222; cyc();
        wsel0 = 5'd3; wdata0 = 32'h3333; wsel1 = 5'd23; wdata1 = 32'h2323; cyc();
        idle(); we0 = 1'b1; wsel0 = 5'd30; wdata0 = 32'hFFFF; bset = 1'b1; bsel = 5'd30; cyc();
        idle(); rsel_b = {5'd23, 5'd3, 5'd2, 5'd1};
        settle();
        push("p0_r1", 1, 0, 32'h1111, 1'b0);
        push("p1_r2", 1, 1, 32'h2222, 1'b0);
        push("p2_r3", 1, 2, 32'h3333, 1'b0);
        push("p3_r23", 1, 3, 32'h2323, 1'b0);
        tick();
        idle(); rsel_b = {5'd30, 5'd30, 5'd30, 5'd30};
        settle();
        push("oob30", 1, 3, 32'h0, 1'b0);
        tick();

        // Random traffic, then a mid-run reset with writes attempted during it
        for (int n = 0; n < 150; n++) rand_cycle();
        idle(); rst_n = 1'b0; we0 = 1'b1; wsel0 = 5'd5; wdata0 = 32'hCAFE0005;
        we1 = 1'b1; wsel1 = 5'd7; wdata1 = 32'hCAFE0007; bset = 1'b1; bsel = 5'd6;
        rsel_a = {5'd7, 5'd5}; rsel_b = {5'd23, 5'd7, 5'd6, 5'd5};
        settle();
        push("rst_rd0", 0, 0, 32'd0, 1'b0);
        push("rst_rd1", 0, 1, 32'd0, 1'b0);
        push("rst_bany_a", 0, -1, 32'd0, 1'b0);
        push("rst_bany_b", 1, -1, 32'd0, 1'b0);
        tick();
        cyc();
        idle(); rst_n = 1'b1; rsel_a = {5'd7, 5'd5};
        settle();
        push("post_rst5", 0, 0, 32'd0, 1'b0);
        tick();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            rand_cycle();
        end
        rst_n = 1'b1;
        idle();
        cyc();

        #20;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
